// File: rtl/fcbaps_gen2.sv
// APB slave bridge onto the FCB write FIFO and cfg read FIFO.
// Optional wait-state timeout is built when FCBAPS_GEN2_TIMEOUT_EN is defined.
module fcbaps_gen2 #(
    parameter int unsigned            PAR_DATA_W     = 32,
    parameter int unsigned            PAR_ADDR_W     = 20,
    parameter int unsigned            PAR_SFR_AW     = 7,
    parameter logic [PAR_SFR_AW-1:0]  PAR_CFGDP_ADDR = 'h20,
    parameter int unsigned            PAR_TMO_W      = 8
) (
    input  logic                                          fcb_sys_clk,
    input  logic                                          fcb_sys_rst_n,
    input  logic                                          fcb_sys_stm,
    input  logic                                          fcb_spi_mode_en_bo,
    input  logic                                          fcb_apbs_prot_en_bo,
    input  logic [PAR_TMO_W-1:0]                          fcb_apbs_tmo_val,
    input  logic [PAR_ADDR_W-1:0]                         fcb_apbs_paddr,
    input  logic [2:0]                                    fcb_apbs_pprot,
    input  logic                                          fcb_apbs_psel,
    input  logic                                          fcb_apbs_penable,
    input  logic                                          fcb_apbs_pwrite,
    input  logic [PAR_DATA_W-1:0]                         fcb_apbs_pwdata,
    input  logic [PAR_DATA_W/8-1:0]                       fcb_apbs_pstrb,
    input  logic                                          frwf_wff_full,
    input  logic                                          frwf_crf_empty,
    input  logic [PAR_DATA_W-1:0]                         frwf_crf_rd_data,
    output logic                                          fcb_apbs_pready,
    output logic                                          fcb_apbs_pslverr,
    output logic [PAR_DATA_W-1:0]                         fcb_apbs_prdata,
    output logic                                          faps_frwf_apb_on,
    output logic                                          faps_frwf_wff_wr_en,
    output logic [PAR_SFR_AW+PAR_DATA_W/8+PAR_DATA_W:0]   faps_frwf_wff_wr_data,
    output logic                                          faps_frwf_crf_rd_en
);

    localparam int unsigned STRB_W = PAR_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        CRD_WAIT,
        SREQ,
        SRD_WAIT,
        ACK,
        ERR
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic [PAR_SFR_AW-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [PAR_DATA_W-1:0]   data_q, data_d;

    logic                    is_cfg;
    logic                    access_err;
    logic                    tmo_hit;
    logic [PAR_SFR_AW-1:0]   word_addr;
    logic                    unused_bits;

    assign word_addr  = fcb_apbs_paddr[PAR_SFR_AW+1:2];
    assign is_cfg     = (|fcb_apbs_paddr[PAR_ADDR_W-1:PAR_SFR_AW+2]) ||
                        (word_addr == PAR_CFGDP_ADDR);
    assign access_err = fcb_spi_mode_en_bo ||
                        (fcb_apbs_prot_en_bo && (!fcb_apbs_pprot[0] || fcb_apbs_pprot[1]));
    assign unused_bits = ^{fcb_apbs_paddr[1:0], fcb_apbs_pprot[2]};

    assign faps_frwf_apb_on = ~fcb_spi_mode_en_bo;

`ifdef FCBAPS_GEN2_TIMEOUT_EN
    logic                 in_wait;
    logic [PAR_TMO_W-1:0] cnt_q, cnt_d, cnt_inc;

    assign in_wait = (state_q == WR_WAIT) || (state_q == CRD_WAIT) ||
                     (state_q == SREQ)    || (state_q == SRD_WAIT);
    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = in_wait && (fcb_apbs_tmo_val != '0) && (cnt_inc == fcb_apbs_tmo_val);

    // Held at zero while idle, so every transfer starts counting from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (fcb_sys_stm || (state_q == IDLE)) begin
            cnt_d = '0;
        end else if (in_wait) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = ^fcb_apbs_tmo_val;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d               = state_q;
        wr_d                  = wr_q;
        addr_d                = addr_q;
        strb_d                = strb_q;
        data_d                = data_q;
        fcb_apbs_pready       = 1'b0;
        fcb_apbs_pslverr      = 1'b0;
        fcb_apbs_prdata       = '0;
        faps_frwf_wff_wr_en   = 1'b0;
        faps_frwf_wff_wr_data = '0;
        faps_frwf_crf_rd_en   = 1'b0;

        if (fcb_sys_stm) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fcb_apbs_psel && !fcb_apbs_penable) begin
                        // Reads capture zero strobe/data so the SFR request entry is {0, addr, 0, 0}.
                        wr_d   = fcb_apbs_pwrite;
                        addr_d = is_cfg ? PAR_CFGDP_ADDR : word_addr;
                        strb_d = fcb_apbs_pwrite ? fcb_apbs_pstrb : '0;
                        data_d = fcb_apbs_pwrite ? fcb_apbs_pwdata : '0;
                        if (access_err) begin
                            state_d = ERR;
                        end else if (fcb_apbs_pwrite) begin
                            state_d = WR_WAIT;
                        end else if (is_cfg) begin
                            state_d = CRD_WAIT;
                        end else begin
                            state_d = SREQ;
                        end
                    end
                end
                WR_WAIT: begin
                    if (!fcb_apbs_psel) begin
                        state_d = IDLE;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                    end else if (!frwf_wff_full) begin
                        state_d = ACK;
                    end
                end
                SREQ: begin
                    if (!fcb_apbs_psel) begin
                        state_d = IDLE;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                    end else if (!frwf_wff_full) begin
                        faps_frwf_wff_wr_en   = 1'b1;
                        faps_frwf_wff_wr_data = {wr_q, addr_q, strb_q, data_q};
                        state_d               = SRD_WAIT;
                    end
                end
                CRD_WAIT, SRD_WAIT: begin
                    if (!fcb_apbs_psel) begin
                        state_d = IDLE;
                    end else if (tmo_hit) begin
                        state_d = ERR;
                    end else if (!frwf_crf_empty) begin
                        state_d = ACK;
                    end
                end
                ACK: begin
                    fcb_apbs_pready = 1'b1;
                    if (wr_q) begin
                        faps_frwf_wff_wr_en   = 1'b1;
                        faps_frwf_wff_wr_data = {wr_q, addr_q, strb_q, data_q};
                    end else begin
                        faps_frwf_crf_rd_en = 1'b1;
                        fcb_apbs_prdata     = frwf_crf_rd_data;
                    end
                    state_d = IDLE;
                end
                ERR: begin
                    fcb_apbs_pready  = 1'b1;
                    fcb_apbs_pslverr = 1'b1;
                    state_d          = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_fcbaps_gen2.sv
// Randomized self-checking bench for fcbaps_gen2 with a transaction-level model.
// Timeout expectations follow FCBAPS_GEN2_TIMEOUT_EN when it is defined.
module tb_fcbaps_gen2;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int SAW = 7;
    localparam int TW  = 8;
    localparam int SW  = DW / 8;
    localparam int WW  = 1 + SAW + SW + DW;
    localparam int UW  = AW - SAW - 2;
    localparam logic [SAW-1:0] CFGDP = 7'h20;
`ifdef FCBAPS_GEN2_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stm = 1'b0, spi = 1'b0, pen = 1'b0;
    logic [TW-1:0] tmo = '0;
    logic [AW-1:0] paddr = '0;
    logic [2:0]    pprot = '0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [DW-1:0] pwdata = '0;
    logic [SW-1:0] pstrb = '0;
    logic          full = 1'b0, empty = 1'b1;
    logic [DW-1:0] rdata_in = '0;
    logic          pready, pslverr, apb_on, wen, ren;
    logic [DW-1:0] prdata;
    logic [WW-1:0] wdata;

    always #5 clk = ~clk;

    fcbaps_gen2 #(
        .PAR_DATA_W(DW), .PAR_ADDR_W(AW), .PAR_SFR_AW(SAW),
        .PAR_CFGDP_ADDR(CFGDP), .PAR_TMO_W(TW)
    ) dut (
        .fcb_sys_clk(clk), .fcb_sys_rst_n(rst_n), .fcb_sys_stm(stm),
        .fcb_spi_mode_en_bo(spi), .fcb_apbs_prot_en_bo(pen), .fcb_apbs_tmo_val(tmo),
        .fcb_apbs_paddr(paddr), .fcb_apbs_pprot(pprot), .fcb_apbs_psel(psel),
        .fcb_apbs_penable(penable), .fcb_apbs_pwrite(pwrite), .fcb_apbs_pwdata(pwdata),
        .fcb_apbs_pstrb(pstrb), .frwf_wff_full(full), .frwf_crf_empty(empty),
        .frwf_crf_rd_data(rdata_in), .fcb_apbs_pready(pready), .fcb_apbs_pslverr(pslverr),
        .fcb_apbs_prdata(prdata), .faps_frwf_apb_on(apb_on), .faps_frwf_wff_wr_en(wen),
        .faps_frwf_wff_wr_data(wdata), .faps_frwf_crf_rd_en(ren)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txn_start = 0;

    logic          exp_rdy = 1'b0, exp_err = 1'b0, exp_wen = 1'b0, exp_ren = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [WW-1:0] exp_wdata = '0;

    int            n_push = 0, n_pop = 0, n_rdy = 0, n_slverr = 0, last_rdy_cyc = 0;
    logic [WW-1:0] last_push = '0;
    logic [DW-1:0] last_rdata = '0;

    bit            env_full[64];
    bit            env_empty[64];
    logic [DW-1:0] env_rd[64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Single compare process: every cycle, DUT outputs against the model's expectations.
    initial forever begin
        @(negedge clk);
        check("pready", pready, exp_rdy);
        check("pslverr", pslverr, exp_err);
        check("prdata", prdata, exp_rdata);
        check("wff_wr_en", wen, exp_wen);
        check("crf_rd_en", ren, exp_ren);
        check("apb_on", apb_on, !spi);
        if (exp_wen || !rst_n) check("wff_wr_data", wdata, exp_wdata);
        if (wen) begin n_push++; last_push = wdata; end
        if (ren) begin n_pop++; last_rdata = prdata; end
        if (pready) begin n_rdy++; last_rdy_cyc = cyc; end
        if (pslverr) n_slverr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic rdy, input logic err, input logic [DW-1:0] rd,
                           input logic we, input logic [WW-1:0] wd, input logic re);
        exp_rdy = rdy; exp_err = err; exp_rdata = rd;
        exp_wen = we;  exp_wdata = wd; exp_ren = re;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            psel = 1'b0; penable = 1'b0; stm = 1'b0; spi = 1'b0;
            full = 1'($urandom); empty = 1'($urandom); rdata_in = $urandom;
            set_exp(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        end
    endtask

    task automatic set_env(input int full_until, input int empty_until);
        for (int i = 0; i < 64; i++) begin
            env_full[i]  = (i < full_until);
            env_empty[i] = (i < empty_until);
            env_rd[i]    = $urandom;
        end
    endtask

    task automatic rand_env();
        for (int i = 0; i < 64; i++) begin
            env_full[i]  = (i < 30) && ($urandom_range(0, 99) < 60);
            env_empty[i] = (i < 30) && ($urandom_range(0, 99) < 60);
            env_rd[i]    = $urandom;
        end
    endtask

    // Transaction model: cycle 0 is the setup phase, access cycles count from 1.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] strb, input logic [2:0] prot, input bit spi_i,
                           input bit pen_i, input logic [TW-1:0] tmo_i, input int abort_at,
                           input bit abort_stm);
        bit            is_cfg, bad, tmo_on, pushed, pop, resp_err, aborted;
        logic [SAW-1:0] fa;
        logic [WW-1:0] push_val;
        int            resp_cyc, push_cyc, last;
        is_cfg   = (addr[AW-1:SAW+2] != '0) || (addr[SAW+1:2] == CFGDP);
        fa       = is_cfg ? CFGDP : addr[SAW+1:2];
        bad      = spi_i || (pen_i && (!prot[0] || prot[1]));
        tmo_on   = TMO_EN && (tmo_i != '0);
        pushed   = 1'b0; pop = 1'b0; resp_err = 1'b0; aborted = 1'b0;
        resp_cyc = -1; push_cyc = -1; last = 0; push_val = '0;
        if (bad) begin
            resp_cyc = 1; resp_err = 1'b1;
        end else begin
            for (int k = 1; k < 60; k++) begin
                if (k == abort_at) begin aborted = 1'b1; last = k; break; end
                if (tmo_on && k == int'(tmo_i)) begin resp_cyc = k + 1; resp_err = 1'b1; break; end
                if (wr) begin
                    if (!env_full[k]) begin
                        resp_cyc = k + 1; push_cyc = k + 1;
                        push_val = {1'b1, fa, strb, wd};
                        break;
                    end
                end else if (!is_cfg && !pushed) begin
                    if (!env_full[k]) begin
                        pushed = 1'b1; push_cyc = k;
                        push_val = {1'b0, fa, {SW{1'b0}}, {DW{1'b0}}};
                    end
                end else if (!env_empty[k]) begin
                    resp_cyc = k + 1; pop = 1'b1;
                    break;
                end
            end
        end
        if (!aborted) last = resp_cyc;
        for (int c = 0; c <= last; c++) begin
            tick();
            psel    = !(aborted && !abort_stm && c == last);
            penable = (c != 0);
            stm     = aborted && abort_stm && c == last;
            if (c == 0) begin
                pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb; pprot = prot;
                spi = spi_i; pen = pen_i; tmo = tmo_i; txn_start = cyc;
            end
            full = env_full[c]; empty = env_empty[c]; rdata_in = env_rd[c];
            set_exp(c == resp_cyc, (c == resp_cyc) && resp_err,
                    (c == resp_cyc && pop) ? env_rd[c] : '0,
                    c == push_cyc, push_val, (c == resp_cyc) && pop);
        end
    endtask

    initial begin
        int p0, q0, r0, s0;
        set_exp(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        idle(2);

        // Plain write to SFR word 4.
        p0 = n_push; r0 = n_rdy; s0 = n_slverr;
        set_env(0, 64);
        run_txn(1'b1, 20'h00010, 32'hA5A5_0001, 4'hF, 3'b001, 1'b0, 1'b0, '0, 0, 1'b0);
        idle(1);
        check("w_push_cnt", n_push - p0, 1);
        check("w_push_data", last_push, 44'h84F_A5A5_0001);
        check("w_ready_cnt", n_rdy - r0, 1);
        check("w_slverr_cnt", n_slverr - s0, 0);

        // Cfg data-port read: FIFO empty for cycles 0..5, ready the cycle after it fills.
        q0 = n_pop;
        set_env(0, 6);
        run_txn(1'b0, 20'h00080, '0, '0, 3'b001, 1'b0, 1'b0, '0, 0, 1'b0);
        idle(1);
        check("cr_latency", last_rdy_cyc - txn_start, 7);
        check("cr_pop_cnt", n_pop - q0, 1);
        check("cr_prdata", last_rdata, env_rd[7]);

        // SFR read of word 3: request push then pop.
        p0 = n_push; q0 = n_pop;
        set_env(0, 3);
        run_txn(1'b0, 20'h0000C, '0, '0, 3'b001, 1'b0, 1'b0, '0, 0, 1'b0);
        idle(1);
        check("sr_push_data", last_push, 44'h030_0000_0000);
        check("sr_push_cnt", n_push - p0, 1);
        check("sr_pop_cnt", n_pop - q0, 1);
        check("sr_latency", last_rdy_cyc - txn_start, 4);

        // Protection violation.
        p0 = n_push; s0 = n_slverr;
        set_env(0, 0);
        run_txn(1'b1, 20'h00010, 32'h1234_5678, 4'hF, 3'b000, 1'b0, 1'b1, '0, 0, 1'b0);
        idle(1);
        check("prot_slverr_cnt", n_slverr - s0, 1);
        check("prot_push_cnt", n_push - p0, 0);
        check("prot_latency", last_rdy_cyc - txn_start, 1);

`ifdef FCBAPS_GEN2_TIMEOUT_EN
        p0 = n_push; s0 = n_slverr;
        set_env(64, 64);
        run_txn(1'b1, 20'h00020, 32'hDEAD_BEEF, 4'h3, 3'b001, 1'b0, 1'b0, 8'd4, 0, 1'b0);
        idle(1);
        check("tmo_latency", last_rdy_cyc - txn_start, 5);
        check("tmo_slverr_cnt", n_slverr - s0, 1);
        check("tmo_push_cnt", n_push - p0, 0);
        p0 = n_push; s0 = n_slverr;
        set_env(10, 64);
        run_txn(1'b1, 20'h00020, 32'hDEAD_BEEF, 4'h3, 3'b001, 1'b0, 1'b0, 8'd0, 0, 1'b0);
        idle(1);
`else
        p0 = n_push; s0 = n_slverr;
        set_env(10, 64);
        run_txn(1'b1, 20'h00020, 32'hDEAD_BEEF, 4'h3, 3'b001, 1'b0, 1'b0, 8'd4, 0, 1'b0);
        idle(1);
`endif
        check("unb_latency", last_rdy_cyc - txn_start, 11);
        check("unb_push_cnt", n_push - p0, 1);
        check("unb_slverr_cnt", n_slverr - s0, 0);

        // Reset in the middle of a stalled write abandons it.
        p0 = n_push; r0 = n_rdy;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00014;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF; pen = 1'b0; tmo = '0; full = 1'b1;
        set_exp(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        repeat (3) begin tick(); penable = 1'b1; end
        tick(); rst_n = 1'b0;
        tick(); full = 1'b0;
        tick(); rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        idle(2);
        check("rst_push_cnt", n_push - p0, 0);
        check("rst_ready_cnt", n_rdy - r0, 0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            bit            wr, sp, pe, ab, abs_;
            int            sel, ab_at;
            logic [UW-1:0] up;
            logic [SAW-1:0] wa;
            logic [TW-1:0] tv;
            wr  = 1'($urandom);
            sel = $urandom_range(0, 5);
            up  = (sel < 2) ? UW'($urandom_range(1, (1 << UW) - 1)) : '0;
            wa  = (sel == 2) ? CFGDP : SAW'($urandom);
            sp  = ($urandom_range(0, 9) == 0);
            pe  = ($urandom_range(0, 2) == 0);
            tv  = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 12));
            ab  = !sp && !pe && ($urandom_range(0, 5) == 0);
            abs_ = 1'($urandom);
            ab_at = ab ? $urandom_range(1, 8) : 0;
            rand_env();
            run_txn(wr, {up, wa, 2'($urandom)}, $urandom, SW'($urandom), 3'($urandom),
                    sp, pe, tv, ab_at, abs_);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
